// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared constants and helpers for the branch resolve unit:
//   - BranchSelect condition encodings
//   - 2-bit branch history counter states
//   - statistics counter width / saturation value
//   - saturating update helpers for history counters and statistics
// ---------------------------------------------------------------------------
package branch_pkg;

  // Condition codes carried on BranchSelect
  localparam logic [2:0] SEL_BLT       = 3'b000;
  localparam logic [2:0] SEL_BGT       = 3'b001;
  localparam logic [2:0] SEL_BEQ       = 3'b010;
  localparam logic [2:0] SEL_BEQ_ALIAS = 3'b011;  // legacy encoding of BEQ
  localparam logic [2:0] SEL_BNE       = 3'b100;
  localparam logic [2:0] SEL_BGE       = 3'b101;
  localparam logic [2:0] SEL_BLE       = 3'b110;
  localparam logic [2:0] SEL_BAL       = 3'b111;

  // Branch history counter states; MSB is the taken prediction
  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  // Statistics counters
  localparam int              STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = {STAT_W{1'b1}};

  // Saturating history counter step toward the resolved direction
  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cur == BHT_ST) ? BHT_ST : cur + 2'd1;
    end else begin
      nxt = (cur == BHT_SNT) ? BHT_SNT : cur - 2'd1;
    end
    return nxt;
  endfunction

  // Statistics increment that sticks at the all-ones value
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    logic [STAT_W-1:0] nxt;
    nxt = v;
    if (en && (v != STAT_SAT)) begin
      nxt = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
//   ENTRIES x 2-bit saturating direction counters.
//   Ports:
//     clk, reset   clock / asynchronous active-high reset (entries -> WNT)
//     rd_idx       combinational lookup index
//     rd_taken     prediction (MSB of the addressed counter)
//     wr_en        update strobe
//     wr_idx       index of the counter to update
//     wr_taken     resolved direction for the update
//   The read port sees the registered counters, so a lookup that hits the
//   entry being updated in the same cycle returns the pre-update value.
// ---------------------------------------------------------------------------
module branch_history_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  // Per-entry prediction bits gathered for the read mux
  logic [ENTRIES-1:0] predict_bits;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [1:0] ctr_q;
      logic [1:0] ctr_d;

      always_comb begin
        ctr_d = ctr_q;
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          ctr_d = bht_next(ctr_q, wr_taken);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ctr_q <= BHT_WNT;
        end else begin
          ctr_q <= ctr_d;
        end
      end

      assign predict_bits[gi] = ctr_q[1];
    end
  endgenerate

  assign rd_taken = predict_bits[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves conditional branches / jumps, checks the carried prediction,
//   trains a 2-bit history table, drives a multi-cycle flush on mispredict
//   and keeps saturating branch / mispredict statistics.
//   Ports:
//     clk, reset        clock / asynchronous active-high reset
//     FetchPC           fetch-stage PC for prediction lookup
//     PredictTaken      combinational table prediction for FetchPC
//     ValidIn           resolve-stage instruction valid
//     ResolvePC         PC of the instruction being resolved
//     A, B              compare operands
//     BranchSelect      condition code (see branch_pkg)
//     Branch, Jump      conditional branch / unconditional jump
//     PredictedTaken    prediction that travelled with the instruction
//     Taken             registered resolved direction (holds between resolves)
//     Mispredict        registered one-cycle mispredict pulse
//     FlushOut          registered flush, high FLUSH_CYCLES cycles
//     BranchCount       saturating count of resolved branches and jumps
//     MispredictCount   saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int PC_WIDTH     = 16,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter bit SIGNED_CMP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] FetchPC,
  output logic                PredictTaken,
  input  logic                ValidIn,
  input  logic [PC_WIDTH-1:0] ResolvePC,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [2:0]          BranchSelect,
  input  logic                Branch,
  input  logic                Jump,
  input  logic                PredictedTaken,
  output logic                Taken,
  output logic                Mispredict,
  output logic                FlushOut,
  output logic [STAT_W-1:0]   BranchCount,
  output logic [STAT_W-1:0]   MispredictCount
);

  localparam int              IDX_W      = $clog2(BHT_ENTRIES);
  localparam int              FC_W       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);

  // -------------------------------------------------------------------------
  // Operand comparison
  // -------------------------------------------------------------------------
  logic lt;
  logic gt;
  logic eq;

  always_comb begin
    if (SIGNED_CMP) begin
      lt = $signed(A) < $signed(B);
      gt = $signed(A) > $signed(B);
    end else begin
      lt = A < B;
      gt = A > B;
    end
    eq = (A == B);
  end

  logic cond_met;

  always_comb begin
    cond_met = 1'b0;
    case (BranchSelect)
      SEL_BLT:       cond_met = lt;
      SEL_BGT:       cond_met = gt;
      SEL_BEQ:       cond_met = eq;
      SEL_BEQ_ALIAS: cond_met = eq;
      SEL_BNE:       cond_met = ~eq;
      SEL_BGE:       cond_met = ~lt;
      SEL_BLE:       cond_met = ~gt;
      SEL_BAL:       cond_met = 1'b1;
      default:       cond_met = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Resolve decision
  // -------------------------------------------------------------------------
  logic [FC_W-1:0] flush_cnt_q;
  logic [FC_W-1:0] flush_cnt_d;
  logic            accept;
  logic            taken_calc;
  logic            mispredict_calc;
  logic            bht_wr_en;

  // Anything arriving while the flush counter runs is wrong-path work.
  assign accept          = ValidIn & (flush_cnt_q == '0);
  assign taken_calc      = Jump | (Branch & cond_met);
  // A non-branch that was predicted taken (aliased table hit) also counts.
  assign mispredict_calc = accept & (taken_calc != PredictedTaken);
  // Only conditional branches train the table; jumps would pollute it.
  assign bht_wr_en       = accept & Branch & ~Jump;

  // -------------------------------------------------------------------------
  // History table
  // -------------------------------------------------------------------------
  branch_history_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (FetchPC[IDX_W-1:0]),
    .rd_taken (PredictTaken),
    .wr_en    (bht_wr_en),
    .wr_idx   (ResolvePC[IDX_W-1:0]),
    .wr_taken (taken_calc)
  );

  generate
    if (PC_WIDTH > IDX_W) begin : g_pc_upper
      logic unused_pc_upper;
      assign unused_pc_upper = ^{FetchPC[PC_WIDTH-1:IDX_W], ResolvePC[PC_WIDTH-1:IDX_W]};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State update
  // -------------------------------------------------------------------------
  logic              taken_q;
  logic              taken_d;
  logic              mispredict_q;
  logic              mispredict_d;
  logic              flush_out_q;
  logic              flush_out_d;
  logic [STAT_W-1:0] branch_count_q;
  logic [STAT_W-1:0] branch_count_d;
  logic [STAT_W-1:0] mispredict_count_q;
  logic [STAT_W-1:0] mispredict_count_d;

  always_comb begin
    taken_d            = taken_q;
    mispredict_d       = mispredict_calc;
    flush_cnt_d        = flush_cnt_q;
    branch_count_d     = sat_inc(branch_count_q, accept & (Branch | Jump));
    mispredict_count_d = sat_inc(mispredict_count_q, mispredict_calc);

    if (accept) begin
      taken_d = taken_calc;
    end

    // A mispredict can only be raised with the counter at zero, so load and
    // countdown never compete.
    if (mispredict_calc) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FC_W'(1);
    end

    flush_out_d = (flush_cnt_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_q            <= 1'b0;
      mispredict_q       <= 1'b0;
      flush_cnt_q        <= '0;
      flush_out_q        <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      taken_q            <= taken_d;
      mispredict_q       <= mispredict_d;
      flush_cnt_q        <= flush_cnt_d;
      flush_out_q        <= flush_out_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign Taken           = taken_q;
  assign Mispredict      = mispredict_q;
  assign FlushOut        = flush_out_q;
  assign BranchCount     = branch_count_q;
  assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed stimulus against branch_resolve_unit (signed instance plus an
//   unsigned-compare instance sharing the same inputs). A behavioural model
//   tracks expected outputs; one compare process checks every cycle, and a
//   set of hand-computed literal checks pins the model.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int ENT   = 16;
  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] FetchPC;
  logic        PredictTaken;
  logic        ValidIn;
  logic [15:0] ResolvePC;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  BranchSelect;
  logic        Branch;
  logic        Jump;
  logic        PredictedTaken;
  logic        Taken;
  logic        Mispredict;
  logic        FlushOut;
  logic [15:0] BranchCount;
  logic [15:0] MispredictCount;

  logic        u_taken;
  logic        u_mis;
  logic        u_flush;
  logic        unused_u_pt;
  logic [15:0] unused_u_bc;
  logic [15:0] unused_u_mc;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .WIDTH(16), .PC_WIDTH(16), .BHT_ENTRIES(ENT), .FLUSH_CYCLES(FLUSH), .SIGNED_CMP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .FetchPC(FetchPC), .PredictTaken(PredictTaken),
    .ValidIn(ValidIn), .ResolvePC(ResolvePC), .A(A), .B(B),
    .BranchSelect(BranchSelect), .Branch(Branch), .Jump(Jump),
    .PredictedTaken(PredictedTaken), .Taken(Taken), .Mispredict(Mispredict),
    .FlushOut(FlushOut), .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  branch_resolve_unit #(
    .WIDTH(16), .PC_WIDTH(16), .BHT_ENTRIES(ENT), .FLUSH_CYCLES(FLUSH), .SIGNED_CMP(1'b0)
  ) u_dut_u (
    .clk(clk), .reset(reset), .FetchPC(FetchPC), .PredictTaken(unused_u_pt),
    .ValidIn(ValidIn), .ResolvePC(ResolvePC), .A(A), .B(B),
    .BranchSelect(BranchSelect), .Branch(Branch), .Jump(Jump),
    .PredictedTaken(PredictedTaken), .Taken(u_taken), .Mispredict(u_mis),
    .FlushOut(u_flush), .BranchCount(unused_u_bc), .MispredictCount(unused_u_mc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  int m_bht [ENT];
  int m_bc;
  int m_mc;
  int m_flush;
  int m_taken;
  int m_mis;
  bit preload_req = 1'b0;
  bit cmp_en      = 1'b0;

  function automatic int model_taken(input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] sel, input logic br, input logic jmp);
    int av;
    int bv;
    int c;
    av = int'($signed(a));   // signed instance: two's-complement values
    bv = int'($signed(b));
    case (sel)
      3'd0:    c = int'(av <  bv);
      3'd1:    c = int'(av >  bv);
      3'd2:    c = int'(av == bv);
      3'd3:    c = int'(av == bv);
      3'd4:    c = int'(av != bv);
      3'd5:    c = int'(av >= bv);
      3'd6:    c = int'(av <= bv);
      default: c = 1;
    endcase
    if (jmp) return 1;
    if (br)  return c;
    return 0;
  endfunction

  initial begin : model_proc
    int t;
    int idx;
    bit acc;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < ENT; i++) m_bht[i] = 1;
        m_bc = 0; m_mc = 0; m_flush = 0; m_taken = 0; m_mis = 0;
      end else begin
        acc = ValidIn && (m_flush == 0);
        if (m_flush > 0) m_flush = m_flush - 1;
        m_mis = 0;
        if (preload_req) m_mc = 65534;
        if (acc) begin
          t = model_taken(A, B, BranchSelect, Branch, Jump);
          m_taken = t;
          if (t != int'(PredictedTaken)) begin
            m_mis = 1;
            m_flush = FLUSH;
            if (m_mc < 65535) m_mc = m_mc + 1;
          end
          if ((Branch || Jump) && m_bc < 65535) m_bc = m_bc + 1;
          if (Branch && !Jump) begin
            idx = int'(ResolvePC) % ENT;
            if (t == 1) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
            else        m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare
  // -------------------------------------------------------------------------
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("taken",      int'(Taken),           m_taken);
        chk("mispredict", int'(Mispredict),      m_mis);
        chk("flush",      int'(FlushOut),        int'(m_flush != 0));
        chk("br_count",   int'(BranchCount),     m_bc);
        chk("mis_count",  int'(MispredictCount), m_mc);
        chk("predict",    int'(PredictTaken),    int'(m_bht[int'(FetchPC) % ENT] >= 2));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [15:0] pc, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] sel,
                       input bit br, input bit jmp, input bit pt);
    ValidIn = v; ResolvePC = pc; A = a; B = b; BranchSelect = sel;
    Branch = br; Jump = jmp; PredictedTaken = pt;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] vec_a [5];
  logic [15:0] vec_b [5];

  initial begin
    reset = 1'b1; FetchPC = '0; ValidIn = 0; ResolvePC = '0; A = '0; B = '0;
    BranchSelect = '0; Branch = 0; Jump = 0; PredictedTaken = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_taken", int'(Taken), 0);
    chk("rst_mis",   int'(Mispredict), 0);
    chk("rst_flush", int'(FlushOut), 0);
    chk("rst_bc",    int'(BranchCount), 0);
    chk("rst_mc",    int'(MispredictCount), 0);
    cmp_en = 1'b1;

    // Idle sweep of every table index
    for (int i = 0; i < ENT; i++) begin
      FetchPC = 16'(i);
      idle();
      chk("rst_pred", int'(PredictTaken), 0);
    end

    // Signed vs unsigned BLT: -1 < 1 only when signed
    drive(1, 16'd3, 16'hFFFF, 16'd1, 3'd0, 1, 0, 0);
    chk("blt_taken", int'(Taken), 1);
    chk("blt_mis",   int'(Mispredict), 1);
    chk("blt_fl1",   int'(FlushOut), 1);
    chk("u_taken",   int'(u_taken), 0);
    chk("u_mis",     int'(u_mis), 0);
    chk("u_flush",   int'(u_flush), 0);
    idle();
    chk("blt_fl2",   int'(FlushOut), 1);
    chk("blt_mis2",  int'(Mispredict), 0);
    idle();
    chk("blt_fl3",   int'(FlushOut), 0);

    // History training on PC 5: 01 -> 10 -> 11 -> 10
    FetchPC = 16'd5;
    drive(1, 16'd5, 16'd7, 16'd7, 3'd2, 1, 0, 1);
    chk("bht_p1",    int'(PredictTaken), 1);
    chk("bht_mis1",  int'(Mispredict), 0);
    drive(1, 16'd5, 16'd7, 16'd7, 3'd2, 1, 0, 1);
    chk("bht_p2",    int'(PredictTaken), 1);
    chk("b2b_bc",    int'(BranchCount), 3);
    chk("b2b_flush", int'(FlushOut), 0);
    drive(1, 16'd5, 16'd7, 16'd7, 3'd4, 1, 0, 1);
    chk("bht_p3",    int'(PredictTaken), 1);
    chk("bht_nt",    int'(Taken), 0);
    chk("bht_mis3",  int'(Mispredict), 1);
    idle();
    idle();

    // Resolve during flush is ignored
    FetchPC = 16'd7;
    drive(1, 16'd7, 16'd5, 16'd2, 3'd1, 1, 0, 0);
    chk("wp_mis",    int'(Mispredict), 1);
    drive(1, 16'd7, 16'd1, 16'd1, 3'd4, 1, 0, 0);
    chk("wp_bc",     int'(BranchCount), 5);
    chk("wp_mc",     int'(MispredictCount), 3);
    chk("wp_taken",  int'(Taken), 1);
    chk("wp_mis2",   int'(Mispredict), 0);
    chk("wp_pred",   int'(PredictTaken), 1);
    chk("wp_fl",     int'(FlushOut), 1);
    idle();
    chk("wp_fl_end", int'(FlushOut), 0);

    // Jump predicted taken; non-branch predicted taken
    FetchPC = 16'd9;
    drive(1, 16'd9, 16'd5, 16'd1, 3'd0, 0, 1, 1);
    chk("jmp_taken", int'(Taken), 1);
    chk("jmp_mis",   int'(Mispredict), 0);
    chk("jmp_bc",    int'(BranchCount), 6);
    chk("jmp_pred",  int'(PredictTaken), 0);
    drive(1, 16'd9, 16'd0, 16'd0, 3'd7, 0, 0, 1);
    chk("nb_mis",    int'(Mispredict), 1);
    chk("nb_flush",  int'(FlushOut), 1);
    chk("nb_taken",  int'(Taken), 0);
    chk("nb_bc",     int'(BranchCount), 6);
    chk("nb_mc",     int'(MispredictCount), 4);
    idle();
    idle();

    // Condition sweep, model-checked
    vec_a[0] = 16'hFFFF; vec_b[0] = 16'h0001;
    vec_a[1] = 16'h0001; vec_b[1] = 16'hFFFF;
    vec_a[2] = 16'h8000; vec_b[2] = 16'h7FFF;
    vec_a[3] = 16'h1234; vec_b[3] = 16'h1234;
    vec_a[4] = 16'h0000; vec_b[4] = 16'h0000;
    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < 8; s++) begin
        FetchPC = 16'(s + 8);
        drive(1, 16'(s + 8), vec_a[v], vec_b[v], 3'(s), 1, 0, s[0]);
        idle();
        idle();
      end
    end

    // Mispredict counter saturation
    cmp_en = 1'b0;
    force dut.mispredict_count_q = 16'hFFFE;
    preload_req = 1'b1;
    idle();
    release dut.mispredict_count_q;
    preload_req = 1'b0;
    cmp_en = 1'b1;
    chk("sat_pre",   int'(MispredictCount), 'hFFFE);
    drive(1, 16'd2, 16'd0, 16'd0, 3'd7, 0, 0, 1);
    chk("sat_max",   int'(MispredictCount), 'hFFFF);
    idle();
    idle();
    drive(1, 16'd2, 16'd0, 16'd0, 3'd7, 0, 0, 1);
    chk("sat_hold",  int'(MispredictCount), 'hFFFF);
    chk("sat_fl",    int'(FlushOut), 1);

    // Asynchronous reset in the middle of a flush
    #1 reset = 1'b1;
    #1;
    chk("ar_flush",  int'(FlushOut), 0);
    chk("ar_mc",     int'(MispredictCount), 0);
    chk("ar_taken",  int'(Taken), 0);
    idle();
    reset = 1'b0;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction-check unit for the pipelined datapath, succeeding the combinational branch comparator in the decode/execute boundary. Compares two operands under an extended condition set with signed or unsigned arithmetic, registers the taken decision, and checks it against the fetch-stage prediction. Maintains a 2-bit saturating branch history table and drives a multi-cycle flush only on mispredict. Keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- WIDTH, 16, operand width
- PC_WIDTH, 16, program counter width
- BHT_ENTRIES, 16, history table depth; power of two, ≥2; index = PC[log2(BHT_ENTRIES)-1:0]
- FLUSH_CYCLES, 2, cycles FlushOut is held per mispredict; ≥1
- SIGNED_CMP, 1, 1 = ordered compares are two's-complement, 0 = unsigned

Ports (one clock `clk`; reset `reset` is asynchronous, active-high):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-high reset
- FetchPC  in  PC_WIDTH  fetch-stage PC for prediction lookup
- PredictTaken  out  1  combinational BHT prediction for FetchPC (counter MSB)
- ValidIn  in  1  resolve-stage instruction valid
- ResolvePC  in  PC_WIDTH  PC of instruction being resolved
- A, B  in  WIDTH  compare operands
- BranchSelect  in  3  condition code
- Branch  in  1  conditional branch
- Jump  in  1  unconditional jump
- PredictedTaken  in  1  prediction carried down the pipeline with the instruction
- Taken  out  1  registered resolved direction
- Mispredict  out  1  registered single-cycle mispredict pulse
- FlushOut  out  1  registered flush, held FLUSH_CYCLES
- BranchCount  out  16  saturating count of resolved branches and jumps
- MispredictCount  out  16  saturating count of mispredicts

## Operation
- Conditions: 000 BLT, 001 BGT, 010 BEQ, 011 BEQ (legacy alias), 100 BNE, 101 BGE, 110 BLE, 111 BAL (always). Ordered codes use SIGNED_CMP; EQ/NE independent of it.
- Cond result gated by Branch; Jump forces Taken=1 regardless of BranchSelect.
- Accepted resolve = ValidIn & !FlushOut-busy (flush counter nonzero). Non-accepted cycles change no state except flush countdown.
- Mispredict on accepted resolve when computed taken ≠ PredictedTaken; includes PredictedTaken=1 with Branch=Jump=0 (aliased prediction on non-branch).
- BHT update on accepted resolve with Branch=1 only: counter ++ if taken, -- if not, saturating at 00/11. Jumps and non-branches never update.
- BranchCount ++ on accepted resolve with Branch|Jump; MispredictCount ++ on accepted mispredict; both saturate at 16'hFFFF.
- Flush counter: loaded with FLUSH_CYCLES on mispredict; decrements each cycle to 0; FlushOut = counter ≠ 0.

## Timing
- Reset values: Taken 0, Mispredict 0, FlushOut 0, counters 0, flush counter 0, all BHT entries 2'b01 (weakly not-taken); PredictTaken follows table (0 after reset).
- Latency: accepted resolve at edge t → Taken/Mispredict valid cycle t+1; FlushOut high cycles t+1 … t+FLUSH_CYCLES.
- Mispredict is a one-cycle pulse; Taken holds last accepted value until next accepted resolve.
- Lookup read-before-write: FetchPC index equal to updating index in the same cycle returns pre-update value.
- Resolve during active flush is wrong-path: ignored, no reload, no BHT/counter update.
- Back-to-back accepted resolves with no mispredict: one per cycle, no bubbles.
- Reset asserted mid-flush clears flush counter and outputs immediately (async).

## Structure
- Package `branch_pkg`: BranchSelect encodings as named localparams, BHT state constants (SNT 00, WNT 01, WT 10, ST 11), counter saturation value.
- Sub-module `branch_history_table`: BHT_ENTRIES×2-bit array, combinational read port, synchronous saturating update port, async reset to WNT.
- Top holds condition evaluation, flush counter, statistics counters, output registers.

## Test plan
- Reset then idle: all outputs 0, PredictTaken 0 for every FetchPC.
- SIGNED_CMP=1, A=16'hFFFF, B=1, BLT, Branch=1, PredictedTaken=0 → Taken=1, Mispredict=1 next cycle, FlushOut high exactly 2 cycles; with SIGNED_CMP=0 → Taken=0, no flush.
- Same ResolvePC taken twice, Branch=1 → BHT entry 01→10→11; PredictTaken for that PC goes 1 after first update; a third not-taken drops it to 10, still predicts 1.
- Mispredict followed by ValidIn branch next cycle (during flush) → ignored: BranchCount unchanged, no BHT change, FlushOut ends on schedule.
- Jump with PredictedTaken=1 → Taken=1, no Mispredict, BranchCount +1, BHT untouched; non-branch with PredictedTaken=1 → Mispredict=1, flush.
- Preload 65 535 mispredicts then one more → MispredictCount stays 16'hFFFF; assert reset mid-flush → FlushOut drops without clock edge.
